// File: rtl/ysyx_040066_mem_arbiter.sv
// Three-master arbiter (I-fetch, D-read, D-write) in front of one downstream memory port.
// Arbitrates whole transactions, round-robin between I and D, and serializes writeback lines into 64-bit beats.
module ysyx_040066_mem_arbiter #(
    parameter int BEATS  = 8,
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ins_req,
    input  logic                ins_burst,
    input  logic [ADDR_W-1:0]   ins_addr,
    output logic                ins_ready,
    output logic                ins_err,
    output logic                ins_last,
    output logic [63:0]         ins_data,

    input  logic                rd_req,
    input  logic                rd_burst,
    input  logic [2:0]          rd_len,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_ready,
    output logic                rd_err,
    output logic                rd_last,
    output logic [63:0]         rd_data,

    input  logic                wr_req,
    input  logic                wr_burst,
    input  logic [2:0]          wr_len,
    input  logic [7:0]          wr_mask,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [64*BEATS-1:0] wr_data,
    output logic                wr_ready,
    output logic                wr_err,

    output logic                mem_valid,
    output logic                mem_we,
    output logic                mem_burst,
    output logic [2:0]          mem_size,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic                mem_rvalid,
    input  logic                mem_rlast,
    input  logic                mem_rerr,
    input  logic [63:0]         mem_rdata,
    output logic                mem_wvalid,
    output logic                mem_wlast,
    output logic [63:0]         mem_wdata,
    output logic [7:0]          mem_wstrb,
    input  logic                mem_wready,
    input  logic                mem_bvalid,
    input  logic                mem_berr
);

    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_W = 64 * BEATS;

    typedef enum logic [2:0] {IDLE, ADDR, RDATA, WDATA, WRESP} state_t;
    typedef enum logic [1:0] {OWN_I, OWN_DR, OWN_DW} owner_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              burst;
        logic [2:0]        size;
        logic [7:0]        mask;
    } req_t;

    state_t            state, state_nx;
    owner_t            owner, gnt_owner;
    logic              last_side_d;  // 1: D-side held the port most recently
    logic [CNT_W-1:0]  cnt, cnt_nx;
    req_t              req_q, gnt_req;
    logic [LINE_W-1:0] line_q;
    logic              d_req, d_win, grant;
    logic              beat_last, wlast;

    // Arbitration: D wins unless I also wants the port and D went last.
    always_comb begin
        d_req     = rd_req | wr_req;
        d_win     = d_req & (~ins_req | ~last_side_d);
        grant     = (state == IDLE) & (d_win | ins_req);
        gnt_owner = OWN_I;
        if (d_win)
            gnt_owner = wr_req ? OWN_DW : OWN_DR;

        gnt_req = '0;
        case (gnt_owner)
            OWN_DW: begin
                gnt_req.addr  = wr_addr;
                gnt_req.burst = wr_burst;
                gnt_req.size  = wr_burst ? 3'd3 : wr_len;
                gnt_req.mask  = wr_burst ? 8'hFF : wr_mask;
            end
            OWN_DR: begin
                gnt_req.addr  = rd_addr;
                gnt_req.burst = rd_burst;
                gnt_req.size  = rd_burst ? 3'd3 : rd_len;
                gnt_req.mask  = 8'hFF;
            end
            default: begin
                // Uncached instruction fetch is a 32-bit access.
                gnt_req.addr  = ins_addr;
                gnt_req.burst = ins_burst;
                gnt_req.size  = ins_burst ? 3'd3 : 3'd2;
                gnt_req.mask  = 8'hFF;
            end
        endcase
    end

    assign beat_last = ~req_q.burst | mem_rlast;
    assign wlast     = ~req_q.burst | (cnt == CNT_W'(BEATS - 1));

    assign mem_we    = (owner == OWN_DW);
    assign mem_burst = req_q.burst;
    assign mem_size  = req_q.size;
    assign mem_addr  = req_q.addr;
    assign mem_wstrb = req_q.mask;
    assign mem_wdata = line_q[{cnt, 6'd0} +: 64];
    assign ins_data  = mem_rdata;
    assign rd_data   = mem_rdata;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        mem_valid  = 1'b0;
        mem_wvalid = 1'b0;
        mem_wlast  = 1'b0;
        ins_ready  = 1'b0;
        ins_err    = 1'b0;
        ins_last   = 1'b0;
        rd_ready   = 1'b0;
        rd_err     = 1'b0;
        rd_last    = 1'b0;
        wr_ready   = 1'b0;
        wr_err     = 1'b0;

        case (state)
            IDLE: begin
                if (grant)
                    state_nx = ADDR;
            end
            ADDR: begin
                mem_valid = 1'b1;
                if (mem_ack) begin
                    state_nx = (owner == OWN_DW) ? WDATA : RDATA;
                    cnt_nx   = '0;
                end
            end
            RDATA: begin
                if (owner == OWN_I) begin
                    ins_ready = mem_rvalid;
                    ins_err   = mem_rvalid & mem_rerr;
                    ins_last  = mem_rvalid & beat_last;
                end else begin
                    rd_ready  = mem_rvalid;
                    rd_err    = mem_rvalid & mem_rerr;
                    rd_last   = mem_rvalid & beat_last;
                end
                if (mem_rvalid && beat_last)
                    state_nx = IDLE;
            end
            WDATA: begin
                mem_wvalid = 1'b1;
                mem_wlast  = wlast;
                if (mem_wready) begin
                    if (wlast) begin
                        state_nx = WRESP;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx   = cnt + 1'b1;
                    end
                end
            end
            WRESP: begin
                wr_ready = mem_bvalid;
                wr_err   = mem_bvalid & mem_berr;
                if (mem_bvalid)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= OWN_I;
            last_side_d <= 1'b1;
            cnt         <= '0;
            req_q       <= '0;
            line_q      <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (grant) begin
                owner       <= gnt_owner;
                last_side_d <= (gnt_owner != OWN_I);
                req_q       <= gnt_req;
                if (gnt_owner == OWN_DW)
                    line_q <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_040066_mem_arbiter.sv
// Self-checking bench for ysyx_040066_mem_arbiter: scripted memory responder plus beat scoreboards.
module tb_ysyx_040066_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic ins_req, ins_burst, ins_ready, ins_err, ins_last;
    logic [63:0] ins_addr, ins_data;
    logic rd_req, rd_burst, rd_ready, rd_err, rd_last;
    logic [2:0] rd_len;
    logic [63:0] rd_addr, rd_data;
    logic wr_req, wr_burst, wr_ready, wr_err;
    logic [2:0] wr_len;
    logic [7:0] wr_mask;
    logic [63:0] wr_addr;
    logic [511:0] wr_data;
    logic mem_valid, mem_we, mem_burst, mem_ack;
    logic [2:0] mem_size;
    logic [63:0] mem_addr, mem_rdata, mem_wdata;
    logic mem_rvalid, mem_rlast, mem_rerr;
    logic mem_wvalid, mem_wlast, mem_wready, mem_bvalid, mem_berr;
    logic [7:0] mem_wstrb;

    ysyx_040066_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ins_req(ins_req), .ins_burst(ins_burst), .ins_addr(ins_addr),
        .ins_ready(ins_ready), .ins_err(ins_err), .ins_last(ins_last), .ins_data(ins_data),
        .rd_req(rd_req), .rd_burst(rd_burst), .rd_len(rd_len), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .rd_err(rd_err), .rd_last(rd_last), .rd_data(rd_data),
        .wr_req(wr_req), .wr_burst(wr_burst), .wr_len(wr_len), .wr_mask(wr_mask),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .wr_err(wr_err),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_burst(mem_burst), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rlast(mem_rlast), .mem_rerr(mem_rerr), .mem_rdata(mem_rdata),
        .mem_wvalid(mem_wvalid), .mem_wlast(mem_wlast), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_wready(mem_wready), .mem_bvalid(mem_bvalid), .mem_berr(mem_berr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        err;
        logic        last;
    } beat_t;

    beat_t        rq[$];
    beat_t        wq[$];
    int           checks = 0;
    int           failures = 0;
    bit           ls_d;      // model of the side granted most recently (1 = D)
    logic [511:0] line;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        int n;
        n  = 0;
        ok = mem_valid;
        while (!ok && n < 20) begin
            step();
            n++;
            ok = mem_valid;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_bvalid = 1'b1;
        step();
        step();
        checks++;
        if ({mem_valid, mem_wvalid, ins_ready, ins_err, ins_last, rd_ready, rd_err, rd_last, wr_ready, wr_err} !== 10'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 0", {mem_valid, mem_wvalid, ins_ready, ins_err, ins_last, rd_ready, rd_err, rd_last, wr_ready, wr_err});
        end
        rst = 1'b0;
        mem_rvalid = 1'b0;
        mem_bvalid = 1'b0;
        ls_d = 1'b1;
        step();
        checks++;
        if ({mem_valid, ins_ready, rd_ready, wr_ready} !== 4'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got %b want 0", {mem_valid, ins_ready, rd_ready, wr_ready});
        end
    endtask

    task automatic test_i_single();
        bit ok;
        beat_t e;
        ins_addr = 64'h8000_0004; ins_burst = 1'b0; ins_req = 1'b1;
        wait_valid(ok);
        ls_d = 1'b0;
        checks++;
        if (!ok || mem_addr !== 64'h8000_0004 || mem_we !== 1'b0 || mem_burst !== 1'b0) begin
            failures++;
            $display("FAIL isingle_addr: got ok=%0d addr=%h we=%b burst=%b want addr=80000004 we=0 burst=0", ok, mem_addr, mem_we, mem_burst);
        end
        repeat (2) begin
            step();
            checks++;
            if (mem_valid !== 1'b1 || mem_addr !== 64'h8000_0004) begin
                failures++;
                $display("FAIL isingle_hold: got valid=%b addr=%h want 1 80000004", mem_valid, mem_addr);
            end
        end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        checks++;
        if (ins_ready !== 1'b0 || mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL isingle_wait: got ready=%b valid=%b want 0 0", ins_ready, mem_valid);
        end
        rq.push_back('{64'h1234, 1'b0, 1'b1});
        mem_rvalid = 1'b1; mem_rdata = 64'h1234; mem_rlast = 1'b0; mem_rerr = 1'b0;
        #1;
        e = rq.pop_front();
        checks++;
        if (ins_ready !== 1'b1 || ins_last !== e.last || ins_err !== e.err || ins_data !== e.data || rd_ready !== 1'b0) begin
            failures++;
            $display("FAIL isingle_beat: got rdy=%b last=%b err=%b data=%h rd_rdy=%b want 1 %b %b %h 0", ins_ready, ins_last, ins_err, ins_data, rd_ready, e.last, e.err, e.data);
        end
        ins_req = 1'b0;
        step();
        mem_rvalid = 1'b0;
        step();
        checks++;
        if (mem_valid !== 1'b0 || ins_ready !== 1'b0) begin
            failures++;
            $display("FAIL isingle_done: got valid=%b rdy=%b want 0 0", mem_valid, ins_ready);
        end
    endtask

    task automatic test_writeback_refill();
        bit ok;
        beat_t e;
        for (int i = 0; i < 64; i++) line[8*i +: 8] = i[7:0];
        for (int k = 0; k < 8; k++) wq.push_back('{line[64*k +: 64], 1'b0, (k == 7)});
        wr_data = line; wr_addr = 64'h8000_1000; wr_burst = 1'b1; wr_mask = 8'h00;
        rd_addr = 64'h8000_2000; rd_burst = 1'b1;
        wr_req = 1'b1; rd_req = 1'b1;
        wait_valid(ok);
        ls_d = 1'b1;
        checks++;
        if (!ok || mem_we !== 1'b1 || mem_addr !== 64'h8000_1000 || mem_burst !== 1'b1 || mem_size !== 3'd3) begin
            failures++;
            $display("FAIL wb_addr: got ok=%0d we=%b addr=%h burst=%b size=%0d want 1 80001000 1 3", ok, mem_we, mem_addr, mem_burst, mem_size);
        end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        mem_wready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e = wq.pop_front();
            checks++;
            if (mem_wvalid !== 1'b1 || mem_wdata !== e.data || mem_wlast !== e.last || mem_wstrb !== 8'hFF) begin
                failures++;
                $display("FAIL wb_beat%0d: got v=%b data=%h last=%b strb=%h want 1 %h %b ff", k, mem_wvalid, mem_wdata, mem_wlast, mem_wstrb, e.data, e.last);
            end
            step();
        end
        mem_wready = 1'b0;
        checks++;
        if (mem_wvalid !== 1'b0 || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL wb_resp_wait: got wvalid=%b wr_ready=%b want 0 0", mem_wvalid, wr_ready);
        end
        step();
        mem_bvalid = 1'b1; mem_berr = 1'b0;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || wr_err !== 1'b0) begin
            failures++;
            $display("FAIL wb_resp: got ready=%b err=%b want 1 0", wr_ready, wr_err);
        end
        wr_req = 1'b0;
        step();
        mem_bvalid = 1'b0;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL wb_pulse: got ready=%b want 0", wr_ready);
        end
        wait_valid(ok);
        ls_d = 1'b1;
        checks++;
        if (!ok || mem_we !== 1'b0 || mem_addr !== 64'h8000_2000 || mem_burst !== 1'b1) begin
            failures++;
            $display("FAIL refill_addr: got ok=%0d we=%b addr=%h burst=%b want 1 0 80002000 1", ok, mem_we, mem_addr, mem_burst);
        end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mem_rvalid = 1'b1; mem_rdata = 64'hD000 + 64'(k); mem_rlast = (k == 7); mem_rerr = 1'b0;
            #1;
            checks++;
            if (rd_ready !== 1'b1 || ins_ready !== 1'b0 || rd_data !== 64'hD000 + 64'(k) || rd_last !== (k == 7)) begin
                failures++;
                $display("FAIL refill_beat%0d: got rdy=%b irdy=%b data=%h last=%b", k, rd_ready, ins_ready, rd_data, rd_last);
            end
            if (k == 7) rd_req = 1'b0;
            step();
        end
        mem_rvalid = 1'b0; mem_rlast = 1'b0;
    endtask

    task automatic test_error();
        bit ok;
        beat_t e;
        for (int k = 0; k < 8; k++) rq.push_back('{64'hA000 + 64'(k), (k == 2), (k == 7)});
        ins_addr = 64'h8000_0040; ins_burst = 1'b1; ins_req = 1'b1;
        wait_valid(ok);
        ls_d = 1'b0;
        checks++;
        if (!ok || mem_addr !== 64'h8000_0040 || mem_burst !== 1'b1 || mem_size !== 3'd3) begin
            failures++;
            $display("FAIL err_addr: got ok=%0d addr=%h burst=%b size=%0d", ok, mem_addr, mem_burst, mem_size);
        end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mem_rvalid = 1'b1; mem_rdata = 64'hA000 + 64'(k); mem_rerr = (k == 2); mem_rlast = (k == 7);
            #1;
            e = rq.pop_front();
            checks++;
            if (ins_ready !== 1'b1 || ins_err !== e.err || ins_last !== e.last || ins_data !== e.data) begin
                failures++;
                $display("FAIL err_beat%0d: got rdy=%b err=%b last=%b data=%h want 1 %b %b %h", k, ins_ready, ins_err, ins_last, ins_data, e.err, e.last, e.data);
            end
            if (k == 7) ins_req = 1'b0;
            step();
        end
        mem_rvalid = 1'b0; mem_rerr = 1'b0; mem_rlast = 1'b0;
        #1;
        checks++;
        if (ins_ready !== 1'b0 || mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_done: got rdy=%b valid=%b want 0 0", ins_ready, mem_valid);
        end
    endtask

    task automatic test_round_robin();
        bit ok, exp_d;
        logic [63:0] exp_addr;
        ins_addr = 64'h1000; ins_burst = 1'b0;
        rd_addr = 64'h2000; rd_burst = 1'b0; rd_len = 3'd3;
        ins_req = 1'b1; rd_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_d = ~ls_d;
            exp_addr = exp_d ? 64'h2000 : 64'h1000;
            ls_d = exp_d;
            wait_valid(ok);
            checks++;
            if (!ok || mem_addr !== exp_addr) begin
                failures++;
                $display("FAIL rr_grant%0d: got ok=%0d addr=%h want %h", t, ok, mem_addr, exp_addr);
            end
            mem_ack = 1'b1; step(); mem_ack = 1'b0;
            mem_rvalid = 1'b1; mem_rdata = 64'(t); mem_rlast = 1'b1;
            #1;
            checks++;
            if ({rd_ready, ins_ready} !== (exp_d ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL rr_route%0d: got rd/ins=%b want %b", t, {rd_ready, ins_ready}, exp_d ? 2'b10 : 2'b01);
            end
            if (t == 3) begin ins_req = 1'b0; rd_req = 1'b0; end
            step();
            mem_rvalid = 1'b0; mem_rlast = 1'b0;
        end
    endtask

    task automatic test_single_write();
        bit ok;
        beat_t e;
        wq.push_back('{64'hDEADBEEF, 1'b0, 1'b1});
        wr_data = '0; wr_data[63:0] = 64'hDEADBEEF;
        wr_addr = 64'h8000_3000; wr_burst = 1'b0; wr_len = 3'd2; wr_mask = 8'h0F;
        wr_req = 1'b1;
        wait_valid(ok);
        ls_d = 1'b1;
        checks++;
        if (!ok || mem_we !== 1'b1 || mem_burst !== 1'b0 || mem_size !== 3'd2 || mem_addr !== 64'h8000_3000) begin
            failures++;
            $display("FAIL sw_addr: got ok=%0d we=%b burst=%b size=%0d addr=%h", ok, mem_we, mem_burst, mem_size, mem_addr);
        end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        mem_wready = 1'b1;
        e = wq.pop_front();
        checks++;
        if (mem_wvalid !== 1'b1 || mem_wdata !== e.data || mem_wlast !== e.last || mem_wstrb !== 8'h0F) begin
            failures++;
            $display("FAIL sw_beat: got v=%b data=%h last=%b strb=%h want 1 %h %b 0f", mem_wvalid, mem_wdata, mem_wlast, mem_wstrb, e.data, e.last);
        end
        step();
        mem_wready = 1'b0;
        checks++;
        if (mem_wvalid !== 1'b0) begin
            failures++;
            $display("FAIL sw_one_beat: got wvalid=%b want 0", mem_wvalid);
        end
        mem_bvalid = 1'b1; mem_berr = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b1 || wr_err !== 1'b1) begin
            failures++;
            $display("FAIL sw_resp: got ready=%b err=%b want 1 1", wr_ready, wr_err);
        end
        wr_req = 1'b0;
        step();
        mem_bvalid = 1'b0; mem_berr = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        for (int i = 0; i < 64; i++) line[8*i +: 8] = 8'h80 + i[7:0];
        wr_data = line; wr_addr = 64'h8000_4000; wr_burst = 1'b1; wr_req = 1'b1;
        wait_valid(ok);
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        mem_wready = 1'b1;
        repeat (3) step();
        checks++;
        if (mem_wvalid !== 1'b1 || mem_wdata !== line[255:192]) begin
            failures++;
            $display("FAIL rst_beat4: got v=%b data=%h want 1 %h", mem_wvalid, mem_wdata, line[255:192]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; mem_wready = 1'b0;
        ls_d = 1'b1;
        #1;
        checks++;
        if (mem_wvalid !== 1'b0 || mem_valid !== 1'b0 || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_abort: got wvalid=%b valid=%b wr_ready=%b want 0 0 0", mem_wvalid, mem_valid, wr_ready);
        end
        wait_valid(ok);
        checks++;
        if (!ok || mem_we !== 1'b1 || mem_addr !== 64'h8000_4000) begin
            failures++;
            $display("FAIL rst_regrant: got ok=%0d we=%b addr=%h want 1 1 80004000", ok, mem_we, mem_addr);
        end
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        mem_wready = 1'b1;
        checks++;
        if (mem_wvalid !== 1'b1 || mem_wdata !== line[63:0]) begin
            failures++;
            $display("FAIL rst_first_beat: got v=%b data=%h want 1 %h", mem_wvalid, mem_wdata, line[63:0]);
        end
        repeat (8) step();
        mem_wready = 1'b0;
        mem_bvalid = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_complete: got wr_ready=%b want 1", wr_ready);
        end
        wr_req = 1'b0;
        step();
        mem_bvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ins_req = 1'b0; ins_burst = 1'b0; ins_addr = '0;
        rd_req = 1'b0; rd_burst = 1'b0; rd_len = 3'd0; rd_addr = '0;
        wr_req = 1'b0; wr_burst = 1'b0; wr_len = 3'd0; wr_mask = '0; wr_addr = '0; wr_data = '0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rerr = 1'b0; mem_rdata = '0;
        mem_wready = 1'b0; mem_bvalid = 1'b0; mem_berr = 1'b0;
        line = '0;
        ls_d = 1'b1;
        test_reset();
        test_i_single();
        test_writeback_refill();
        test_error();
        test_round_robin();
        test_single_write();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_040066_mem_arbiter.md
Name: ysyx_040066_mem_arbiter

Overview:
Shares one downstream memory port among the three upstream masters: icache refill/uncached fetch (ins_*), dcache refill/uncached load (rd_*), and dcache writeback/uncached store (wr_*). It sits between the CPU top and the memory/bus bridge. It arbitrates whole transactions, latches the request, and serializes the 512-bit writeback line into 64-bit beats. It routes read beats back to the owning master.

Parameters:
BEATS, 8, beats per burst (one 512-bit line); single accesses are always 1 beat
ADDR_W, 64, address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ins_req  in  1  instruction read request, held until last beat returned
ins_burst  in  1  1 = 8-beat line refill, 0 = single beat
ins_addr  in  64  instruction address
ins_ready  out  1  read beat valid to I-side
ins_err  out  1  error on current I beat
ins_last  out  1  final I beat
ins_data  out  64  I read data
rd_req / rd_burst  in  1 / 1  data read request / burst flag
rd_len  in  3  access size for single reads
rd_addr  in  64  data read address
rd_ready / rd_err / rd_last  out  1 each  data read beat valid / error / final beat
rd_data  out  64  data read beat
wr_req / wr_burst  in  1 / 1  write request / burst flag
wr_len  in  3  access size for single writes
wr_mask  in  8  byte strobe for single writes
wr_addr  in  64  write address
wr_data  in  512  line data; a single write uses [63:0]
wr_ready / wr_err  out  1 / 1  one-cycle write-complete pulse / error
mem_valid  out  1  address phase valid
mem_we  out  1  1 = write transaction
mem_burst  out  1  burst flag
mem_size  out  3  access size (3'd3 for bursts)
mem_addr  out  64  latched address
mem_ack  in  1  address phase accepted
mem_rvalid / mem_rlast / mem_rerr  in  1 each  read beat valid / final / error
mem_rdata  in  64  read beat
mem_wvalid / mem_wlast  out  1 / 1  write beat valid / final write beat
mem_wdata  out  64  write beat
mem_wstrb  out  8  write strobe (8'hFF for bursts)
mem_wready  in  1  write beat accepted
mem_bvalid / mem_berr  in  1 / 1  write response / error

Behaviour:
- States: IDLE, ADDR, RDATA, WDATA, WRESP. Owner register: I, DR, DW.
- Reset: state IDLE, owner I, last_side D, beat counter 0. All mem_* valids 0, all upstream ready/err/last 0. Reset mid-transaction aborts immediately; the downstream side shares rst.
- IDLE arbitration, evaluated each cycle:
  - D-side wins if it requests and (I is idle or last_side == I).
  - Otherwise I wins if it requests.
  - Within the D-side, wr_req beats rd_req, so writeback precedes refill.
  - last_side updates at grant, giving round-robin between I and D.
- Grant latches addr, burst, size, mask and, for writes, the full 512-bit wr_data. Next state is ADDR. Grant costs 1 cycle; no same-cycle bypass.
- ADDR: mem_valid=1 with stable fields until mem_ack. For reads, next state is RDATA. For writes, next state is WDATA with beat counter 0.
- RDATA: mem_rvalid/rlast/rerr/rdata pass combinationally to the owner's ready/last/err/data. The non-owner's ready stays 0. For a single access, ins_last/rd_last=1 on the one beat regardless of mem_rlast. On the final beat, go to IDLE.
- WDATA: mem_wvalid=1 and mem_wdata = latched line[64*cnt +: 64]. The counter advances on mem_wready. mem_wlast=1 at cnt==7 (burst) or on the only beat (single). After the last accepted beat, go to WRESP.
- WRESP: wait for mem_bvalid, then pulse wr_ready for 1 cycle with wr_err=mem_berr, and go to IDLE.
- Errors never truncate a transaction; every beat is still consumed.
- Requesters hold req and fields until completion; changes after grant are ignored. req is sampled again only in IDLE, the cycle after completion.
- Downstream inputs that arrive in an unexpected state are ignored.

Test Plan:
- I-single: ins_req, burst=0, addr=0x8000_0004; mem_ack at t+3, rvalid data 0x1234 -> ins_ready=ins_last=1 with ins_data=0x1234 in the same cycle; rd_ready stays 0.
- Writeback then refill: wr_req and rd_req both burst, line bytes 0x00..0x3F -> mem_we=1 first; beats 0x0706050403020100 … 0x3F3E…38 with wlast on the 8th; wr_ready pulses; then the read address phase is issued.
- Round-robin: ins_req and rd_req held continuously -> grants alternate D, I, D, I over 4 transactions.
- Error: I burst, mem_rerr=1 on beat 3 -> ins_err=1 only on beat 3; all 8 beats are delivered and ins_last comes on beat 8.
- Single masked write: wr_mask=8'h0F, data 0xDEADBEEF -> one beat, mem_wstrb=8'h0F, mem_wlast=1, mem_burst=0.
- Reset at beat 4 of a write burst -> next cycle: IDLE, mem_wvalid=0, wr_ready=0; a new grant follows normally.
